// File: rtl/io_drv_pkg.sv
// Shared IO driver definitions: request codes, sequencer state encoding
// and the legal-opcode helper used by io_cmd_sequencer.
package io_drv_pkg;

  localparam logic [2:0] SPI_WR        = 3'd1;
  localparam logic [2:0] SPI_RD        = 3'd2;
  localparam logic [2:0] COPY_FROM_SPI = 3'd3;
  localparam logic [2:0] COPY_TO_SPI   = 3'd4;
  localparam logic [2:0] EXE_START     = 3'd5;
  localparam logic [2:0] CLK_OUT       = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } seq_state_t;

  // Only the copy, exe and clock requests may come from the command side.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == COPY_FROM_SPI) || (op == COPY_TO_SPI) ||
           (op == EXE_START)     || (op == CLK_OUT);
  endfunction

endpackage

// File: rtl/io_cmd_sequencer.sv
// Sequences one command at a time into the IO driver: latch, strobe,
// then track the req_done acknowledge/done handshake with timeouts.
// Ports: s_clk, reset (sync, high); cmd_valid/cmd_ready/cmd_op/cmd_addr
// command side; drv_addr/drv_request/drv_process_rqst/drv_req_done
// driver side; busy, done_pulse, sticky err_opcode/err_timeout.
// Macro IO_SEQ_DONE_TIMEOUT_EN bounds WAIT_DONE by TIMEOUT_CYCLES.
import io_drv_pkg::*;

module io_cmd_sequencer #(
  parameter int ACK_WINDOW     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       s_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_addr,
  output logic [3:0] drv_addr,
  output logic [2:0] drv_request,
  output logic       drv_process_rqst,
  input  logic       drv_req_done,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_opcode,
  output logic       err_timeout
);

  localparam logic [15:0] ACK_LAST = 16'(ACK_WINDOW - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

`ifdef IO_SEQ_DONE_TIMEOUT_EN
  localparam bit DONE_TO_EN = 1'b1;
`else
  localparam bit DONE_TO_EN = 1'b0;
`endif

  seq_state_t  state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Shared wait counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge s_clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      drv_addr         <= '0;
      drv_request      <= '0;
      drv_process_rqst <= 1'b0;
      done_pulse       <= 1'b0;
      err_opcode       <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      drv_process_rqst <= 1'b0;
      done_pulse       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (op_legal(cmd_op)) begin
              drv_request      <= cmd_op;
              drv_addr         <= cmd_addr;
              drv_process_rqst <= 1'b1;
              state            <= ISSUE;
            end else begin
              err_opcode <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt <= '0;
          // Clock output has no done handshake.
          if (drv_request == CLK_OUT) begin
            state      <= IDLE;
            done_pulse <= 1'b1;
          end else begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!drv_req_done) begin
            state <= WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (drv_req_done) begin
            state      <= IDLE;
            done_pulse <= 1'b1;
          end else if (DONE_TO_EN && (cnt == TO_LAST)) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_cmd_sequencer.md
IO_CMD_SEQUENCER -- requirements
Module: io_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter ACK_WINDOW, default 8: maximum number of cycles after the issue pulse for req_done to fall.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum number of cycles allowed in WAIT_DONE.
REQ-003 The block SHALL have port s_clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port cmd_valid  in  1  a command is presented.
REQ-006 The block SHALL have port cmd_ready  out  1  the sequencer accepts a command this cycle.
REQ-007 The block SHALL have port cmd_op  in  3  driver request code; legal values are 3 (copy_from_spi), 4 (copy_to_spi), 5 (exe_start) and 6 (clock_output).
REQ-008 The block SHALL have port cmd_addr  in  4  IO pin index.
REQ-009 The block SHALL have port drv_addr  out  4  pin address to the IO driver.
REQ-010 The block SHALL have port drv_request  out  3  request code to the IO driver.
REQ-011 The block SHALL have port drv_process_rqst  out  1  one-cycle issue strobe.
REQ-012 The block SHALL have port drv_req_done  in  1  IO driver done level; high means idle.
REQ-013 The block SHALL have port busy  out  1  the sequencer is not in IDLE.
REQ-014 The block SHALL have port done_pulse  out  1  one-cycle pulse when a command completes without error.
REQ-015 The block SHALL have port err_opcode  out  1  sticky flag: an illegal cmd_op was received.
REQ-016 The block SHALL have port err_timeout  out  1  sticky flag: an acknowledge or done timeout occurred.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-018 cmd_ready SHALL equal (state==IDLE), and a command SHALL be accepted on a cycle with cmd_valid && cmd_ready.
REQ-019 On accepting a legal op, the block SHALL register cmd_op and cmd_addr into drv_request and drv_addr and go to ISSUE; both outputs SHALL then hold stable until the block returns to IDLE.
REQ-020 On accepting an illegal op (0, 1, 2 or 7), the block SHALL set err_opcode, stay in IDLE, and issue nothing to the driver.
REQ-021 In ISSUE, drv_process_rqst SHALL be 1 for exactly one cycle.
REQ-022 From ISSUE, op 6 SHALL go to IDLE with done_pulse on the next cycle, because it has no done handshake.
REQ-023 From ISSUE, ops 3, 4 and 5 SHALL go to WAIT_ACK.
REQ-024 In WAIT_ACK, drv_req_done==0 SHALL move the block to WAIT_DONE.
REQ-025 If drv_req_done stays 1 for ACK_WINDOW cycles in WAIT_ACK, the block SHALL go to IDLE, set err_timeout, and give no done_pulse; op 5 with all source FIFOs empty is reported this way.
REQ-026 In WAIT_DONE, drv_req_done==1 SHALL move the block to IDLE with done_pulse=1 on the transition cycle.
REQ-027 Command-to-strobe latency SHALL be 1 cycle: accept on cycle N, drv_process_rqst on cycle N+1.
REQ-028 A cmd_valid asserted while busy SHALL be ignored, not queued.
REQ-029 err_opcode and err_timeout SHALL clear only on reset.
REQ-030 A single 16-bit counter SHALL serve both wait states, clear on each state entry, and saturate rather than wrap.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL force state=IDLE and set drv_addr=0, drv_request=0, drv_process_rqst=0, done_pulse=0, err_opcode=0, err_timeout=0 and counter=0.
REQ-032 Reset asserted mid-command SHALL abort the command with no done_pulse, and the block SHALL accept a new command on the first cycle after reset deasserts.

Configuration
REQ-033 With macro IO_SEQ_DONE_TIMEOUT_EN defined, exceeding TIMEOUT_CYCLES in WAIT_DONE SHALL set err_timeout and return the block to IDLE with no done_pulse.
REQ-034 Without IO_SEQ_DONE_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely; the WAIT_ACK window SHALL always remain in force.

Structure
REQ-035 Shared package io_drv_pkg SHALL hold the request-code constants (SPI_WR=1, SPI_RD=2, COPY_FROM_SPI=3, COPY_TO_SPI=4, EXE_START=5, CLK_OUT=6) and the state encoding.
REQ-036 The block SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-037 Op 3 at addr 5 -> drv_process_rqst one cycle later with drv_addr=5 and drv_request=3; model drops done 2 cycles later and raises it 10 cycles later -> exactly one done_pulse, busy low the next cycle.
REQ-038 Op 6 at addr 15 -> one strobe, done_pulse the cycle after the strobe, no wait on drv_req_done.
REQ-039 Op 2 -> err_opcode=1, drv_process_rqst never asserts, cmd_ready stays 1.
REQ-040 Op 5 with drv_req_done held at 1 -> err_timeout after 8 cycles in WAIT_ACK, no done_pulse.
REQ-041 Reset pulsed during WAIT_DONE -> all outputs at reset values; a new op 4 is accepted on the next cycle.
REQ-042 With IO_SEQ_DONE_TIMEOUT_EN and TIMEOUT_CYCLES=20, done held low -> err_timeout on cycle 20; without the macro, the block stays busy indefinitely.
